// File: rtl/counter_sched.sv
// Round-robin time-slot scheduler sharing one up-counter among NREQ requesters.
// Optional `COUNTER_SCHED_ABORT_EN: granted requester dropping req aborts its interval.
module counter_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   len_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    busy_o,
  output logic                    cnt_rst_o,
  output logic                    cnt_en_o,
  input  logic [WIDTH-1:0]        cnt_count_i
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic               busy_q, busy_d;
  logic               cnt_rst_q, cnt_rst_d;
  logic [WIDTH-1:0]   len_q, len_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   ptr_next;

  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   cand;
  logic               abort_c;

  // First requesting index at or after the pointer, wrapping upward
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PTR_W'((32'(ptr_q) + k) % NREQ);
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef COUNTER_SCHED_ABORT_EN
  assign abort_c = ~req_i[gidx_q];
`else
  assign abort_c = 1'b0;
`endif

  assign ptr_next = (gidx_q == PTR_W'(NREQ - 1)) ? '0 : gidx_q + PTR_W'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    busy_d    = busy_q;
    cnt_rst_d = 1'b0;
    len_d     = len_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d         = CLEAR;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          len_d           = len_i[32'(pick_idx)*WIDTH +: WIDTH];
          gidx_d          = pick_idx;
          busy_d          = 1'b1;
          cnt_rst_d       = 1'b1;
        end
      end
      CLEAR, RUN: begin
        if (abort_c) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_next;
        end else if (state_q == CLEAR) begin
          state_d = RUN;
        end else if (cnt_count_i >= len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = gnt_q;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_next;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      cnt_rst_q <= 1'b0;
      len_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      cnt_rst_q <= cnt_rst_d;
      len_q     <= len_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
    end
  end

  // Counter enable stops exactly at len, so the count never wraps
  assign cnt_en_o  = (state_q == RUN) && (cnt_count_i < len_q);
  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign cnt_rst_o = cnt_rst_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural up-counter model attached.
module tb_counter_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] len;
  logic [1:0] gnt, done;
  logic       busy, cnt_rst, cnt_en;
  logic [3:0] cnt_count = 4'd9;

  int n_tests = 0;
  int n_fail  = 0;

  counter_sched #(.WIDTH(4), .NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .len_i(len),
    .gnt_o(gnt), .done_o(done), .busy_o(busy),
    .cnt_rst_o(cnt_rst), .cnt_en_o(cnt_en), .cnt_count_i(cnt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_rst)     cnt_count <= 4'd0;
    else if (cnt_en) cnt_count <= cnt_count + 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; len = '0;
    tick(); tick();
    n_tests++; if (gnt !== 2'b00)  begin n_fail++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    n_tests++; if (done !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b exp 00", done); end
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (cnt_rst !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_rst got %b exp 0", cnt_rst); end
    n_tests++; if (cnt_en !== 1'b0)  begin n_fail++; $display("FAIL reset_cnt_en got %b exp 0", cnt_en); end
    rst_n = 1'b1;
    tick();
  endtask

  // One full service of requester idx with interval l; req dropped in the done cycle
  task automatic test_interval(input int idx, input logic [3:0] l);
    int         last;
    logic [1:0] oh;
    logic [1:0] exp_gnt, exp_done;
    logic       exp_en, exp_rst, exp_busy;
    last = int'(l) + 4;
    oh = 2'b01 << idx;
    req = oh;
    len[idx*4 +: 4] = l;
    for (int k = 1; k <= last; k++) begin
      tick();
      exp_gnt  = (k < last) ? oh : 2'b00;
      exp_done = (k == last) ? oh : 2'b00;
      exp_en   = (k >= 2) && (k <= int'(l) + 1);
      exp_rst  = (k == 1);
      exp_busy = (k < last);
      n_tests++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL ival%0d_len%0d_gnt T%0d got %b exp %b", idx, l, k, gnt, exp_gnt); end
      n_tests++; if (done !== exp_done) begin n_fail++; $display("FAIL ival%0d_len%0d_done T%0d got %b exp %b", idx, l, k, done, exp_done); end
      n_tests++; if (cnt_en !== exp_en) begin n_fail++; $display("FAIL ival%0d_len%0d_en T%0d got %b exp %b", idx, l, k, cnt_en, exp_en); end
      n_tests++; if (cnt_rst !== exp_rst) begin n_fail++; $display("FAIL ival%0d_len%0d_rst T%0d got %b exp %b", idx, l, k, cnt_rst, exp_rst); end
      n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL ival%0d_len%0d_busy T%0d got %b exp %b", idx, l, k, busy, exp_busy); end
      if (k >= 2 && k <= int'(l) + 2) begin
        n_tests++;
        if (cnt_count !== 4'(k - 2)) begin n_fail++; $display("FAIL ival%0d_len%0d_count T%0d got %0d exp %0d", idx, l, k, cnt_count, k - 2); end
      end
      if (k == last) req = '0;
    end
  endtask

  task automatic test_len_change();
    int en_cycles = 0;
    req = 2'b01; len[3:0] = 4'd5;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 2) len[3:0] = 4'd2;
      if (cnt_en === 1'b1) en_cycles++;
      if (k == 7) begin
        n_tests++; if (cnt_count !== 4'd5) begin n_fail++; $display("FAIL lenchg_count got %0d exp 5", cnt_count); end
      end
      if (k == 8) begin
        n_tests++; if (done !== 2'b00) begin n_fail++; $display("FAIL lenchg_early_done got %b exp 00", done); end
      end
    end
    n_tests++; if (done !== 2'b01) begin n_fail++; $display("FAIL lenchg_done got %b exp 01", done); end
    n_tests++; if (en_cycles != 5) begin n_fail++; $display("FAIL lenchg_en_cycles got %0d exp 5", en_cycles); end
    req = '0;
    tick();
  endtask

  // Reset during RUN of requester 1 (pointer at 1 beforehand)
  task automatic test_mid_reset();
    req = 2'b10; len[7:4] = 4'd8;
    for (int k = 1; k <= 4; k++) tick();
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL midrst_pre_gnt got %b exp 10", gnt); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (gnt !== 2'b00)  begin n_fail++; $display("FAIL midrst_gnt got %b exp 00", gnt); end
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_tests++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL midrst_en got %b exp 0", cnt_en); end
    req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (done !== 2'b00) begin n_fail++; $display("FAIL midrst_done cyc%0d got %b exp 00", k, done); end
    end
    n_tests++; if (cnt_count !== 4'd2) begin n_fail++; $display("FAIL midrst_count_held got %0d exp 2", cnt_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_gnt, exp_done;
    req = 2'b11; len = {4'd3, 4'd3};
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k <= 6)       exp_gnt = 2'b01;
      else if (k == 7)  exp_gnt = 2'b00;
      else if (k <= 13) exp_gnt = 2'b10;
      else if (k == 14) exp_gnt = 2'b00;
      else if (k <= 20) exp_gnt = 2'b01;
      else              exp_gnt = 2'b00;
      exp_done = (k == 7 || k == 21) ? 2'b01 : (k == 14) ? 2'b10 : 2'b00;
      n_tests++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL b2b_gnt T%0d got %b exp %b", k, gnt, exp_gnt); end
      n_tests++; if (done !== exp_done) begin n_fail++; $display("FAIL b2b_done T%0d got %b exp %b", k, done, exp_done); end
    end
    req = '0;
    tick();
  endtask

  // Pointer is at 1 here; requester 0 alone wins, requester 1 joins later
  task automatic test_abort();
    req = 2'b01; len = {4'd4, 4'd6};
    tick();
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL abort_gnt0 got %b exp 01", gnt); end
    req = 2'b11;
    tick(); tick();
    req = 2'b10;
`ifdef COUNTER_SCHED_ABORT_EN
    tick();
    n_tests++; if (gnt !== 2'b00)  begin n_fail++; $display("FAIL abort_gnt_t4 got %b exp 00", gnt); end
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL abort_busy_t4 got %b exp 0", busy); end
    n_tests++; if (done !== 2'b00) begin n_fail++; $display("FAIL abort_done_t4 got %b exp 00", done); end
    tick();
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL abort_next_gnt got %b exp 10", gnt); end
`else
    for (int k = 4; k <= 9; k++) begin
      tick();
      n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL noabort_gnt T%0d got %b exp 01", k, gnt); end
    end
    tick();
    n_tests++; if (done !== 2'b01) begin n_fail++; $display("FAIL noabort_done_t10 got %b exp 01", done); end
    tick();
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL noabort_next_gnt got %b exp 10", gnt); end
`endif
    req = '0;
  endtask

  initial begin
    test_reset();
    test_interval(0, 4'd5);
    test_interval(0, 4'd0);
    test_interval(1, 4'd15);
    test_len_change();
    test_mid_reset();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
